// File: rtl/gorev_zamanlayici.sv
// ---------------------------------------------------------------------------
// gorev_zamanlayici
//
// Task scheduler for the image-processing task engines. A start command
// latches which engines take part, enables them, and shares one synchronous
// 8-bit pixel-memory read port between them with a round-robin arbiter. Each
// engine's done flag is collected. One completion pulse is given when every
// selected engine has finished. A watchdog stops the run if it lasts too long.
//
// Ports
//   clk_i           in   clock, rising edge
//   rst_i           in   synchronous reset, active-high; aborts any run at once
//   basla_i         in   start pulse, only looked at while idle
//   gorev_maske_i   in   engines to run, latched on start (all-zero = no start)
//   istek_i         in   per-engine read request
//   adres_i         in   per-engine read address, engine k in slice k
//   islem_bitti_i   in   per-engine done (level or pulse)
//   bellek_adres_o  out  address to the pixel memory (holds when idle)
//   bellek_oku_o    out  memory read strobe
//   bellek_veri_i   in   memory data, valid one cycle after the strobe
//   en_o            out  per-engine enable
//   izin_o          out  one-hot grant, one cycle
//   veri_o          out  returned pixel
//   veri_gecerli_o  out  one-hot data valid, names the owner of veri_o
//   mesgul_o        out  high while a run is active or finishing
//   islem_bitti_o   out  one-cycle pulse when the run is over
//   hata_o          out  sticky watchdog error, cleared by reset or next start
//   durum           out  current FSM state, for observation only
//
// Request/grant handshake: an engine raises istek_i[k] with its address on
// adres_i slice k and keeps both steady until it sees izin_o[k]. The grant
// cycle is the transfer cycle: the request is consumed at that clock edge and
// the engine may drop or change the request in the next cycle. The data for
// that grant comes back on veri_o two cycles later, tagged by
// veri_gecerli_o[k]. There is no back-pressure on the returned data.
// ---------------------------------------------------------------------------
module gorev_zamanlayici #(
    parameter int N_GOREV     = 4,
    parameter int ADR_W       = 17,
    parameter int VERI_W      = 8,
    parameter int ZAMAN_ASIMI = 2000000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       basla_i,
    input  logic [N_GOREV-1:0]         gorev_maske_i,
    input  logic [N_GOREV-1:0]         istek_i,
    input  logic [N_GOREV*ADR_W-1:0]   adres_i,
    input  logic [N_GOREV-1:0]         islem_bitti_i,
    output logic [ADR_W-1:0]           bellek_adres_o,
    output logic                       bellek_oku_o,
    input  logic [VERI_W-1:0]          bellek_veri_i,
    output logic [N_GOREV-1:0]         en_o,
    output logic [N_GOREV-1:0]         izin_o,
    output logic [VERI_W-1:0]          veri_o,
    output logic [N_GOREV-1:0]         veri_gecerli_o,
    output logic                       mesgul_o,
    output logic                       islem_bitti_o,
    output logic                       hata_o,
    output logic [1:0]                 durum
);

    localparam int PTR_W   = (N_GOREV > 1) ? $clog2(N_GOREV) : 1;
    localparam int SAYAC_W = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;
    localparam logic [SAYAC_W-1:0] SAYAC_SON = SAYAC_W'(ZAMAN_ASIMI - 1);

    typedef enum logic [1:0] {
        BOSTA    = 2'd0,
        CALISTIR = 2'd1,
        BITTI    = 2'd2
    } durum_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    durum_t               durum_r;
    logic [N_GOREV-1:0]   mask_r;     // engines taking part in this run
    logic [N_GOREV-1:0]   bitti_r;    // sticky per-engine done
    logic [PTR_W-1:0]     ptr_r;      // index that has top priority next
    logic [ADR_W-1:0]     adres_r;    // last granted address, held when idle
    logic [N_GOREV-1:0]   sira_r;     // owner of the read in flight (stage 1)
    logic [VERI_W-1:0]    veri_r;     // returned pixel (stage 2)
    logic [N_GOREV-1:0]   gecerli_r;  // owner of veri_r (stage 2)
    logic                 hata_r;
    logic [SAYAC_W-1:0]   sayac_r;    // cycles spent in CALISTIR

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [N_GOREV-1:0]   en_c;
    logic [N_GOREV-1:0]   uygun;
    logic                 kazanan_var;
    logic [PTR_W-1:0]     kazanan;
    logic [PTR_W-1:0]     aday;
    logic [N_GOREV-1:0]   izin_c;
    logic [ADR_W-1:0]     adres_sec;
    logic [N_GOREV-1:0]   bitti_sonraki;
    logic                 tamam;
    logic                 hat_bos;

    // Enables follow the registered done bits, so an engine that requests
    // and reports done in the same cycle still gets its grant that cycle.
    always_comb begin
        en_c = '0;
        if (durum_r == CALISTIR && !rst_i) begin
            en_c = mask_r & ~bitti_r;
        end
    end

    // Round-robin search starting at ptr_r, wrapping N_GOREV-1 -> 0.
    // ptr_r always points one past the last winner.
    always_comb begin
        uygun       = istek_i & en_c;
        kazanan_var = 1'b0;
        kazanan     = '0;
        aday        = '0;
        for (int i = 0; i < N_GOREV; i++) begin
            aday = PTR_W'((int'(ptr_r) + i) % N_GOREV);
            if (!kazanan_var && uygun[aday]) begin
                kazanan_var = 1'b1;
                kazanan     = aday;
            end
        end
    end

    always_comb begin
        izin_c    = '0;
        adres_sec = '0;
        for (int k = 0; k < N_GOREV; k++) begin
            if (kazanan_var && kazanan == PTR_W'(k)) begin
                izin_c[k] = 1'b1;
                adres_sec = adres_i[k*ADR_W +: ADR_W];
            end
        end
    end

    // Done inputs of engines outside the mask are dropped here.
    always_comb begin
        bitti_sonraki = bitti_r | (islem_bitti_i & mask_r);
        tamam         = (bitti_sonraki == mask_r);
        // Empty means no read waiting for memory and no pixel being handed out.
        hat_bos       = (sira_r == '0) && (gecerli_r == '0);
    end

    // ------------------------------------------------------------------
    // Sequential logic: FSM, arbiter pointer, read pipeline, watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_r   <= BOSTA;
            mask_r    <= '0;
            bitti_r   <= '0;
            ptr_r     <= '0;
            adres_r   <= '0;
            sira_r    <= '0;
            veri_r    <= '0;
            gecerli_r <= '0;
            hata_r    <= 1'b0;
            sayac_r   <= '0;
        end else begin
            // Two-stage read pipeline: the memory answers one cycle after
            // the strobe, the pixel is registered on the next edge.
            sira_r    <= izin_c;
            gecerli_r <= sira_r;
            if (sira_r != '0) begin
                veri_r <= bellek_veri_i;
            end

            if (kazanan_var) begin
                adres_r <= adres_sec;
                ptr_r   <= PTR_W'((int'(kazanan) + 1) % N_GOREV);
            end

            case (durum_r)
                BOSTA: begin
                    if (basla_i && gorev_maske_i != '0) begin
                        mask_r  <= gorev_maske_i;
                        bitti_r <= '0;
                        sayac_r <= '0;
                        hata_r  <= 1'b0;
                        durum_r <= CALISTIR;
                    end
                end

                CALISTIR: begin
                    bitti_r <= bitti_sonraki;
                    if (tamam) begin
                        durum_r <= BITTI;
                    end else if (sayac_r == SAYAC_SON) begin
                        // Watchdog expiry: finish the run with the error
                        // flag set so the completion pulse still comes out.
                        hata_r  <= 1'b1;
                        durum_r <= BITTI;
                    end else begin
                        sayac_r <= sayac_r + 1'b1;
                    end
                end

                BITTI: begin
                    if (hat_bos) begin
                        durum_r <= BOSTA;
                    end
                end

                default: begin
                    durum_r <= BOSTA;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        en_o           = en_c;
        izin_o         = izin_c;
        bellek_oku_o   = kazanan_var;
        bellek_adres_o = kazanan_var ? adres_sec : adres_r;
        veri_o         = veri_r;
        veri_gecerli_o = gecerli_r;
        mesgul_o       = (durum_r != BOSTA);
        islem_bitti_o  = (durum_r == BITTI) && hat_bos && !rst_i;
        hata_o         = hata_r;
        durum          = durum_r;
    end

endmodule

// File: tb/tb_gorev_zamanlayici.sv
module tb_gorev_zamanlayici;

  localparam int N  = 4;
  localparam int AW = 17;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic            basla_i = 1'b0;
  logic [N-1:0]    gorev_maske_i = '0;
  logic [N-1:0]    istek_i = '0;
  logic [N*AW-1:0] adres_i = '0;
  logic [N-1:0]    islem_bitti_i = '0;
  logic [AW-1:0]   bellek_adres_o;
  logic            bellek_oku_o;
  logic [DW-1:0]   bellek_veri_i = '0;
  logic [N-1:0]    en_o;
  logic [N-1:0]    izin_o;
  logic [DW-1:0]   veri_o;
  logic [N-1:0]    veri_gecerli_o;
  logic            mesgul_o;
  logic            islem_bitti_o;
  logic            hata_o;
  logic [1:0]      durum;

  int n_karsilastirma = 0;
  int n_hata = 0;

  // clock / reset block
  always #5 clk = ~clk;

  gorev_zamanlayici #(
    .N_GOREV(N), .ADR_W(AW), .VERI_W(DW), .ZAMAN_ASIMI(50)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .basla_i(basla_i), .gorev_maske_i(gorev_maske_i),
    .istek_i(istek_i), .adres_i(adres_i), .islem_bitti_i(islem_bitti_i),
    .bellek_adres_o(bellek_adres_o), .bellek_oku_o(bellek_oku_o),
    .bellek_veri_i(bellek_veri_i), .en_o(en_o), .izin_o(izin_o), .veri_o(veri_o),
    .veri_gecerli_o(veri_gecerli_o), .mesgul_o(mesgul_o),
    .islem_bitti_o(islem_bitti_o), .hata_o(hata_o), .durum(durum)
  );

  // pixel memory model: synchronous read, fixed content
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (bellek_oku_o) bellek_veri_i <= mem_f(bellek_adres_o);
  end

  // checker
  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    n_karsilastirma++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  // driver tasks; every cycle step starts 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sifirla();
    rst_i = 1'b1; basla_i = 1'b0; istek_i = '0; islem_bitti_i = '0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic baslat(input logic [N-1:0] m);
    basla_i = 1'b1; gorev_maske_i = m;
    tick();
    basla_i = 1'b0;
  endtask

  // raise the remaining done bits for one cycle, expect a single pulse next cycle
  task automatic bitir(input logic [N-1:0] m);
    islem_bitti_i = m;
    @(negedge clk); kontrol("bitti_erken", islem_bitti_o, 0);
    tick();
    islem_bitti_i = '0;
    @(negedge clk);
    kontrol("bitti_darbe", islem_bitti_o, 1);
    kontrol("bitti_en", en_o, 0);
    kontrol("bitti_mesgul", mesgul_o, 1);
    tick();
    @(negedge clk);
    kontrol("bitti_tek", islem_bitti_o, 0);
    kontrol("bosta_mesgul", mesgul_o, 0);
    tick();
  endtask

  // scoreboard: expected one-hot grant owners and addresses, in order
  logic [N-1:0]  exp_q[$];
  logic [AW-1:0] exp_adr_q[$];

  task automatic kontrol_veri(input string etiket);
    logic [N-1:0]  e;
    logic [AW-1:0] a;
    if (veri_gecerli_o != '0) begin
      if (exp_q.size() == 0) begin
        kontrol({etiket, "_beklenmeyen"}, veri_gecerli_o, 0);
      end else begin
        e = exp_q.pop_front();
        a = exp_adr_q.pop_front();
        kontrol({etiket, "_sahip"}, veri_gecerli_o, e);
        kontrol({etiket, "_veri"}, veri_o, mem_f(a));
      end
    end
  endtask

  initial begin
    logic [N-1:0] beklenen;

    // ---- reset state ----
    sifirla();
    @(negedge clk);
    kontrol("rst_izin", izin_o, 0);
    kontrol("rst_en", en_o, 0);
    kontrol("rst_oku", bellek_oku_o, 0);
    kontrol("rst_adres", bellek_adres_o, 0);
    kontrol("rst_veri", veri_o, 0);
    kontrol("rst_gecerli", veri_gecerli_o, 0);
    kontrol("rst_mesgul", mesgul_o, 0);
    kontrol("rst_bitti", islem_bitti_o, 0);
    kontrol("rst_hata", hata_o, 0);
    tick();

    // ---- single engine, single read ----
    baslat(4'b0001);
    istek_i = 4'b0001; adres_i[0 +: AW] = 17'd5;
    @(negedge clk);
    kontrol("t1_izin", izin_o, 4'b0001);
    kontrol("t1_oku", bellek_oku_o, 1);
    kontrol("t1_adres", bellek_adres_o, 5);
    kontrol("t1_en", en_o, 4'b0001);
    kontrol("t1_mesgul", mesgul_o, 1);
    tick();
    istek_i = '0;
    @(negedge clk);
    kontrol("t1_oku_bos", bellek_oku_o, 0);
    kontrol("t1_adres_tut", bellek_adres_o, 5);
    kontrol("t1_gecerli_t1", veri_gecerli_o, 0);
    tick();
    @(negedge clk);
    kontrol("t1_gecerli_t2", veri_gecerli_o, 4'b0001);
    kontrol("t1_veri_t2", veri_o, 8'h5F);
    tick();
    @(negedge clk); kontrol("t1_gecerli_t3", veri_gecerli_o, 0);
    tick();
    bitir(4'b0001);

    // ---- all four engines requesting back-to-back ----
    sifirla();
    baslat(4'b1111);
    for (int k = 0; k < N; k++) adres_i[k*AW +: AW] = AW'(100 + k);
    for (int i = 0; i < 10; i++) begin
      istek_i = (i < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      beklenen = (i < 8) ? 4'(1 << (i % 4)) : 4'b0000;
      kontrol("rr4_izin", izin_o, beklenen);
      kontrol("rr4_gecerli", veri_gecerli_o, (i >= 2) ? 4'(1 << ((i - 2) % 4)) : 4'b0000);
      if (i >= 2) kontrol("rr4_veri", veri_o, mem_f(AW'(100 + (i - 2) % 4)));
      tick();
    end
    istek_i = '0;
    bitir(4'b1111);

    // ---- mask 0101: only engines 0 and 2, alternating ----
    sifirla();
    baslat(4'b0101);
    for (int i = 0; i < 6; i++) begin
      istek_i = 4'b1111;
      // unmasked done inputs and a start while running must be ignored
      islem_bitti_i = (i == 3) ? 4'b1010 : 4'b0000;
      basla_i = (i == 2);
      gorev_maske_i = (i == 2) ? 4'b1111 : 4'b0101;
      @(negedge clk);
      beklenen = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      kontrol("rr2_izin", izin_o, beklenen);
      kontrol("rr2_en", en_o, 4'b0101);
      if (izin_o != '0) begin
        exp_q.push_back(izin_o == 4'b0001 ? 4'b0001 : 4'b0100);
        exp_adr_q.push_back(izin_o == 4'b0001 ? 17'd100 : 17'd102);
      end
      kontrol_veri("rr2");
      tick();
    end
    basla_i = 1'b0; islem_bitti_i = '0;
    // engine 0 requests and finishes in the same cycle
    istek_i = 4'b0001; islem_bitti_i = 4'b0001;
    @(negedge clk);
    kontrol("ayni_izin", izin_o, 4'b0001);
    exp_q.push_back(4'b0001); exp_adr_q.push_back(17'd100);
    kontrol_veri("ayni");
    tick();
    istek_i = '0; islem_bitti_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      kontrol("ayni_en", en_o, 4'b0100);
      kontrol("ayni_bitti", islem_bitti_o, 0);
      kontrol_veri("ayni");
      tick();
    end
    kontrol("sb_bos", exp_q.size(), 0);
    bitir(4'b0100);

    // ---- watchdog: engine 1 never finishes ----
    baslat(4'b0010);
    for (int c = 1; c < 50; c++) begin
      @(negedge clk);
      kontrol("wd_hata_erken", hata_o, 0);
      tick();
    end
    @(negedge clk);
    kontrol("wd_c50_hata", hata_o, 0);
    kontrol("wd_c50_bitti", islem_bitti_o, 0);
    tick();
    @(negedge clk);
    kontrol("wd_hata", hata_o, 1);
    kontrol("wd_bitti", islem_bitti_o, 1);
    tick();
    @(negedge clk);
    kontrol("wd_hata_kalici", hata_o, 1);
    kontrol("wd_bitti_tek", islem_bitti_o, 0);
    kontrol("wd_mesgul", mesgul_o, 0);
    tick();
    // start with an empty mask is ignored
    baslat(4'b0000);
    @(negedge clk);
    kontrol("bos_maske_mesgul", mesgul_o, 0);
    kontrol("bos_maske_hata", hata_o, 1);
    tick();
    // a real start clears the error
    baslat(4'b0001);
    @(negedge clk);
    kontrol("yeni_hata", hata_o, 0);
    kontrol("yeni_mesgul", mesgul_o, 1);
    kontrol("yeni_en", en_o, 4'b0001);
    tick();
    bitir(4'b0001);

    // ---- reset one cycle after a grant ----
    baslat(4'b0001);
    istek_i = 4'b0001; adres_i[0 +: AW] = 17'd7;
    @(negedge clk); kontrol("ra_izin", izin_o, 4'b0001);
    tick();
    rst_i = 1'b1; istek_i = '0;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    kontrol("ra_gecerli", veri_gecerli_o, 0);
    kontrol("ra_veri", veri_o, 0);
    kontrol("ra_mesgul", mesgul_o, 0);
    kontrol("ra_en", en_o, 0);
    kontrol("ra_adres", bellek_adres_o, 0);
    kontrol("ra_bitti", islem_bitti_o, 0);
    tick();
    @(negedge clk); kontrol("ra_gecerli2", veri_gecerli_o, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_hata);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL zaman_asimi: bench did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
